bound_reduce_sequencer: RTL and testbench
=========================================

// Module: bound_reduce_sequencer
// PURPOSE
//  Time-multiplexed bound reducer for the constraint solver's min/max stage.
//  One signed comparator is shared and stepped over NUM_CONSTRAINTS bound entries.
//  Each entry is a bound value, an activation flag and a sign flag.
//  Produces the tightest lower bound (max of negated sign=1 entries) and the
//  tightest upper bound (min of sign=0 entries), each with a valid flag and the
//  winning entry's index.
//  Sits between the constraint coefficient store and the variable sampler; it
//  replaces a combinational min/max tree when area matters more than latency.
// PARAMETERS
//  NUMBER_SIZE      4  width of each signed bound entry
//  NUM_CONSTRAINTS  8  number of entries scanned per request (>=2)
//  IDX_W            $clog2(NUM_CONSTRAINTS), localparam; width of index outputs
// PORTS
//  clk           in   1                        single clock, rising edge
//  rst_n         in   1                        asynchronous active-low reset
//  start         in   1                        request a scan; sampled only in IDLE
//  bounds        in   NUM_CONSTRAINTS*NUMBER_SIZE  entry i at [i*NUMBER_SIZE +: NUMBER_SIZE], signed
//  activations   in   NUM_CONSTRAINTS          bit i = 1: entry i participates
//  signs         in   NUM_CONSTRAINTS          bit i = 1: lower-bound entry (negated); 0: upper-bound entry
//  busy          out  1                        scan in progress
//  done          out  1                        one-cycle pulse; results valid from this cycle
//  lower         out  NUMBER_SIZE+1            signed max of -bounds[i] over active, sign=1 entries
//  lower_valid   out  1                        at least one active sign=1 entry
//  lower_idx     out  IDX_W                    index of the winning lower entry
//  upper         out  NUMBER_SIZE+1            signed min of bounds[i] over active, sign=0 entries
//  upper_valid   out  1                        at least one active sign=0 entry
//  upper_idx     out  IDX_W                    index of the winning upper entry
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - State goes to IDLE.
//   - busy, done, lower_valid and upper_valid are 0.
//   - lower, upper, lower_idx and upper_idx are 0.
//   - Reset mid-scan aborts the scan; no done pulse follows.
//  FSM states: IDLE -> SCAN -> DONE -> IDLE.
//   - IDLE: start=1 at edge 0 snapshots bounds, activations and signs into
//     internal registers. It also clears the accumulators, sets busy=1 and
//     goes to SCAN. Inputs may change after edge 0.
//   - SCAN: at edges 1..N (N=NUM_CONSTRAINTS) the counter k=0..N-1 processes
//     one entry per edge through the single comparator.
//   - DONE: at edge N+1, results are registered, done=1 and busy=0. At edge
//     N+2, done=0 and the state returns to IDLE.
//   - Latency: start to done is N+1 edges. Back-to-back throughput is one
//     scan per N+2 cycles.
//  Arithmetic
//   - Entries are sign-extended to NUMBER_SIZE+1 bits before negation, so
//     -(-2^(NUMBER_SIZE-1)) is representable; no saturation or wrap.
//   - Entry k, active with sign=1: if lower_valid_acc==0 or -b_k > lower_acc,
//     take -b_k and index k, then set lower_valid_acc=1.
//   - Entry k, active with sign=0: if upper_valid_acc==0 or b_k < upper_acc,
//     take b_k and index k, then set upper_valid_acc=1.
//   - Inactive entries are skipped but still consume their cycle.
//   - Ties keep the earlier entry (strict compare), so the lowest index wins.
//  Outputs
//   - No qualifying entry: the matching *_valid=0 and its value and index are 0.
//   - Results hold from done until the next accepted start.
//   - Results clear to 0 at the edge where that start is accepted.
//  Boundaries
//   - start while busy or in DONE is ignored, not queued.
//   - start held high re-triggers at the first IDLE edge (edge N+2).
//   - The index counter never exceeds N-1; SCAN exits on k==N-1.
//   - lower > upper (infeasible) is reported as-is; it is not flagged here.
// TESTING (NUMBER_SIZE=4, NUM_CONSTRAINTS=4)
//  - bounds={1,5,-2,3} (idx3..0), act=1111, signs=1010, start
//    -> done at edge 5; lower=2 idx1; upper=3 idx0; both valid.
//  - act=0000, start -> done at edge 5; lower_valid=upper_valid=0; all values and indices 0.
//  - bounds[0]=-8, act=0001, signs=0001
//    -> lower=+8 (5-bit 01000) idx0; upper_valid=0.
//  - Upper entries of 2 at idx1 and idx3, others inactive -> upper=2, upper_idx=1 (tie keeps lower index).
//  - start pulsed at edge 2 of a scan -> ignored, a single done;
//    rst_n low at edge 3 -> busy=0, done never pulses, all outputs 0.
//  - start held high -> second scan accepted at edge 6, done again at edge 11;
//    first results held until edge 6.

Source files
------------

// File: rtl/bound_reduce_sequencer_if.sv
// Request/result bundle for the time-multiplexed bound reducer.
// The master drives the request; the slave reports busy/done and both tightest bounds.
interface bound_reduce_sequencer_if #(
    parameter int NUMBER_SIZE     = 4,
    parameter int NUM_CONSTRAINTS = 8
);
    localparam int IDX_W = $clog2(NUM_CONSTRAINTS);

    logic                                   start;
    logic [NUM_CONSTRAINTS*NUMBER_SIZE-1:0] bounds;
    logic [NUM_CONSTRAINTS-1:0]             activations;
    logic [NUM_CONSTRAINTS-1:0]             signs;
    logic                                   busy;
    logic                                   done;
    logic [NUMBER_SIZE:0]                   lower;
    logic                                   lower_valid;
    logic [IDX_W-1:0]                       lower_idx;
    logic [NUMBER_SIZE:0]                   upper;
    logic                                   upper_valid;
    logic [IDX_W-1:0]                       upper_idx;

    modport master (
        output start, bounds, activations, signs,
        input  busy, done, lower, lower_valid, lower_idx,
        input  upper, upper_valid, upper_idx
    );

    modport slave (
        input  start, bounds, activations, signs,
        output busy, done, lower, lower_valid, lower_idx,
        output upper, upper_valid, upper_idx
    );
endinterface

// File: rtl/bound_reduce_sequencer.sv
// Shared-comparator min/max reducer: one bound entry per cycle yields the tightest
// lower bound (max of negated sign=1 entries) and tightest upper bound (min of sign=0 entries).
//
// state  | meaning
// S_IDLE | waiting for start; results of the last scan held, done pulse retires here
// S_SCAN | stepping k = 0..N-1 through the snapshot, one entry per edge
// S_DONE | publishing accumulators to the result registers, pulsing done
module bound_reduce_sequencer #(
    parameter int NUMBER_SIZE     = 4,
    parameter int NUM_CONSTRAINTS = 8
) (
    input logic                       clk,
    input logic                       rst_n,
    bound_reduce_sequencer_if.slave   bus
);
    localparam int IDX_W = $clog2(NUM_CONSTRAINTS);
    localparam int W     = NUMBER_SIZE + 1;
    localparam logic [IDX_W-1:0] LAST_K = IDX_W'(NUM_CONSTRAINTS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                                 state;
    logic [IDX_W-1:0]                       k;
    logic [NUM_CONSTRAINTS*NUMBER_SIZE-1:0] bounds_q;
    logic [NUM_CONSTRAINTS-1:0]             act_q;
    logic [NUM_CONSTRAINTS-1:0]             sign_q;

    logic signed [W-1:0]                    lower_acc;
    logic signed [W-1:0]                    upper_acc;
    logic                                   lower_valid_acc;
    logic                                   upper_valid_acc;
    logic [IDX_W-1:0]                       lower_idx_acc;
    logic [IDX_W-1:0]                       upper_idx_acc;

    logic [NUMBER_SIZE-1:0]                 entry;
    logic signed [W-1:0]                    entry_ext;
    logic signed [W-1:0]                    entry_neg;
    logic signed [W-1:0]                    cmp_a;
    logic signed [W-1:0]                    cmp_b;
    logic                                   cmp_gt;
    logic                                   take;

    // Single comparator: lower asks -b_k > lower_acc, upper asks upper_acc > b_k.
    always_comb begin
        entry     = bounds_q[int'(k)*NUMBER_SIZE +: NUMBER_SIZE];
        entry_ext = {entry[NUMBER_SIZE-1], entry};
        entry_neg = -entry_ext;
        cmp_a     = upper_acc;
        cmp_b     = entry_ext;
        take      = 1'b0;
        if (sign_q[k]) begin
            cmp_a = entry_neg;
            cmp_b = lower_acc;
        end
        cmp_gt = (cmp_a > cmp_b);
        if (act_q[k]) begin
            if (sign_q[k]) take = cmp_gt || !lower_valid_acc;
            else           take = cmp_gt || !upper_valid_acc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            k               <= '0;
            bounds_q        <= '0;
            act_q           <= '0;
            sign_q          <= '0;
            lower_acc       <= '0;
            upper_acc       <= '0;
            lower_valid_acc <= 1'b0;
            upper_valid_acc <= 1'b0;
            lower_idx_acc   <= '0;
            upper_idx_acc   <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.lower       <= '0;
            bus.lower_valid <= 1'b0;
            bus.lower_idx   <= '0;
            bus.upper       <= '0;
            bus.upper_valid <= 1'b0;
            bus.upper_idx   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        bounds_q        <= bus.bounds;
                        act_q           <= bus.activations;
                        sign_q          <= bus.signs;
                        k               <= '0;
                        lower_acc       <= '0;
                        upper_acc       <= '0;
                        lower_valid_acc <= 1'b0;
                        upper_valid_acc <= 1'b0;
                        lower_idx_acc   <= '0;
                        upper_idx_acc   <= '0;
                        bus.lower       <= '0;
                        bus.lower_valid <= 1'b0;
                        bus.lower_idx   <= '0;
                        bus.upper       <= '0;
                        bus.upper_valid <= 1'b0;
                        bus.upper_idx   <= '0;
                        bus.busy        <= 1'b1;
                        state           <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (take) begin
                        if (sign_q[k]) begin
                            lower_acc       <= entry_neg;
                            lower_idx_acc   <= k;
                            lower_valid_acc <= 1'b1;
                        end else begin
                            upper_acc       <= entry_ext;
                            upper_idx_acc   <= k;
                            upper_valid_acc <= 1'b1;
                        end
                    end
                    if (k == LAST_K) state <= S_DONE;
                    else             k     <= k + 1'b1;
                end
                S_DONE: begin
                    bus.lower       <= lower_acc;
                    bus.lower_valid <= lower_valid_acc;
                    bus.lower_idx   <= lower_idx_acc;
                    bus.upper       <= upper_acc;
                    bus.upper_valid <= upper_valid_acc;
                    bus.upper_idx   <= upper_idx_acc;
                    bus.done        <= 1'b1;
                    bus.busy        <= 1'b0;
                    state           <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bound_reduce_sequencer.sv
// Directed bench for bound_reduce_sequencer with N=4, 4-bit entries.
// Expected values are hand-computed from the entry tables in each task.
module tb_bound_reduce_sequencer;
    localparam int NS = 4;
    localparam int NC = 4;

    logic clk;
    logic rst_n;
    int   passed;
    int   total;

    bound_reduce_sequencer_if #(.NUMBER_SIZE(NS), .NUM_CONSTRAINTS(NC)) bus ();

    bound_reduce_sequencer #(.NUMBER_SIZE(NS), .NUM_CONSTRAINTS(NC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a request and return just after the accepting edge (edge 0).
    task automatic start_scan(input logic [15:0] b, input logic [3:0] a, input logic [3:0] s);
        @(negedge clk);
        bus.bounds      = b;
        bus.activations = a;
        bus.signs       = s;
        bus.start       = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Edges after edge 0 until done is seen; -1 if it never arrives.
    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        bus.start       = 1'b0;
        bus.bounds      = '0;
        bus.activations = '0;
        bus.signs       = '0;
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL reset_flags busy=%b done=%b want 0 0", bus.busy, bus.done);
        else passed++;
        total++;
        if (bus.lower_valid !== 1'b0 || bus.upper_valid !== 1'b0)
            $display("FAIL reset_valid lower_valid=%b upper_valid=%b want 0 0", bus.lower_valid, bus.upper_valid);
        else passed++;
        total++;
        if (bus.lower !== 5'd0 || bus.upper !== 5'd0 || bus.lower_idx !== 2'd0 || bus.upper_idx !== 2'd0)
            $display("FAIL reset_values lower=%h upper=%h lidx=%0d uidx=%0d want all 0", bus.lower, bus.upper, bus.lower_idx, bus.upper_idx);
        else passed++;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mixed();
        int n;
        // idx3..0 = 1, 5, -2, 3; sign=1 at idx1, idx3
        start_scan(16'h15E3, 4'b1111, 4'b1010);
        total++;
        if (bus.busy !== 1'b1) $display("FAIL mixed_busy_after_start busy=%b want 1", bus.busy);
        else passed++;
        wait_done(n);
        total++;
        if (n !== 5) $display("FAIL mixed_latency done_edge=%0d want 5", n);
        else passed++;
        total++;
        if (bus.busy !== 1'b0) $display("FAIL mixed_busy_at_done busy=%b want 0", bus.busy);
        else passed++;
        total++;
        if (bus.lower !== 5'd2 || bus.lower_idx !== 2'd1 || bus.lower_valid !== 1'b1)
            $display("FAIL mixed_lower lower=%h idx=%0d valid=%b want 02 1 1", bus.lower, bus.lower_idx, bus.lower_valid);
        else passed++;
        total++;
        if (bus.upper !== 5'd3 || bus.upper_idx !== 2'd0 || bus.upper_valid !== 1'b1)
            $display("FAIL mixed_upper upper=%h idx=%0d valid=%b want 03 0 1", bus.upper, bus.upper_idx, bus.upper_valid);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if (bus.done !== 1'b0) $display("FAIL mixed_done_pulse done=%b want 0", bus.done);
        else passed++;
        total++;
        if (bus.lower !== 5'd2 || bus.upper !== 5'd3) $display("FAIL mixed_hold lower=%h upper=%h want 02 03", bus.lower, bus.upper);
        else passed++;
    endtask

    task automatic test_none_active();
        int n;
        start_scan(16'h15E3, 4'b0000, 4'b1010);
        wait_done(n);
        total++;
        if (n !== 5) $display("FAIL none_latency done_edge=%0d want 5", n);
        else passed++;
        total++;
        if (bus.lower_valid !== 1'b0 || bus.upper_valid !== 1'b0)
            $display("FAIL none_valid lower_valid=%b upper_valid=%b want 0 0", bus.lower_valid, bus.upper_valid);
        else passed++;
        total++;
        if (bus.lower !== 5'd0 || bus.upper !== 5'd0 || bus.lower_idx !== 2'd0 || bus.upper_idx !== 2'd0)
            $display("FAIL none_values lower=%h upper=%h lidx=%0d uidx=%0d want all 0", bus.lower, bus.upper, bus.lower_idx, bus.upper_idx);
        else passed++;
    endtask

    task automatic test_negate_min();
        int n;
        // entry0 = -8 as a lower bound must negate to +8 without wrapping
        start_scan(16'h7778, 4'b0001, 4'b0001);
        wait_done(n);
        total++;
        if (n !== 5) $display("FAIL negmin_latency done_edge=%0d want 5", n);
        else passed++;
        total++;
        if (bus.lower !== 5'b01000 || bus.lower_idx !== 2'd0 || bus.lower_valid !== 1'b1)
            $display("FAIL negmin_lower lower=%b idx=%0d valid=%b want 01000 0 1", bus.lower, bus.lower_idx, bus.lower_valid);
        else passed++;
        total++;
        if (bus.upper_valid !== 1'b0 || bus.upper !== 5'd0)
            $display("FAIL negmin_upper upper=%h valid=%b want 00 0", bus.upper, bus.upper_valid);
        else passed++;
    endtask

    task automatic test_tie();
        int n;
        // idx3..0 = 2, -5, 2, 1; only idx1 and idx3 active, all upper
        start_scan(16'h2B21, 4'b1010, 4'b0000);
        wait_done(n);
        total++;
        if (bus.upper !== 5'd2 || bus.upper_idx !== 2'd1 || bus.upper_valid !== 1'b1)
            $display("FAIL tie_upper upper=%h idx=%0d valid=%b want 02 1 1", bus.upper, bus.upper_idx, bus.upper_valid);
        else passed++;
        total++;
        if (bus.lower_valid !== 1'b0) $display("FAIL tie_lower_valid valid=%b want 0", bus.lower_valid);
        else passed++;
    endtask

    task automatic test_start_ignored();
        int dones;
        int first;
        dones = 0;
        first = -1;
        start_scan(16'h15E3, 4'b1111, 4'b1010);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int e = 3; e <= 14; e++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                dones++;
                if (first < 0) first = e;
            end
        end
        total++;
        if (dones !== 1 || first !== 5) $display("FAIL ignore_start done_count=%0d first_edge=%0d want 1 5", dones, first);
        else passed++;
        total++;
        if (bus.busy !== 1'b0 || bus.lower !== 5'd2) $display("FAIL ignore_idle busy=%b lower=%h want 0 02", bus.busy, bus.lower);
        else passed++;
    endtask

    task automatic test_reset_mid_scan();
        int dones;
        dones = 0;
        start_scan(16'h15E3, 4'b1111, 4'b1010);
        @(posedge clk);
        @(posedge clk);
        #1;
        total++;
        if (bus.busy !== 1'b1) $display("FAIL abort_busy_before busy=%b want 1", bus.busy);
        else passed++;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.lower !== 5'd0 || bus.upper !== 5'd0 ||
            bus.lower_valid !== 1'b0 || bus.upper_valid !== 1'b0)
            $display("FAIL abort_outputs busy=%b done=%b lower=%h upper=%h lv=%b uv=%b want all 0",
                     bus.busy, bus.done, bus.lower, bus.upper, bus.lower_valid, bus.upper_valid);
        else passed++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 0; e < 10; e++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) dones++;
        end
        total++;
        if (dones !== 0) $display("FAIL abort_no_done active_cycles=%0d want 0", dones);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int n;
        start_scan(16'h15E3, 4'b1111, 4'b1010);
        bus.start = 1'b1;
        // idx3..0 = -3, 7, 4, -1; sign=1 at idx0, idx1
        bus.bounds      = 16'hD74F;
        bus.signs       = 4'b0011;
        wait_done(n);
        total++;
        if (n !== 5) $display("FAIL b2b_first_latency done_edge=%0d want 5", n);
        else passed++;
        total++;
        if (bus.lower !== 5'd2 || bus.lower_idx !== 2'd1 || bus.upper !== 5'd3 || bus.upper_idx !== 2'd0)
            $display("FAIL b2b_first_results lower=%h lidx=%0d upper=%h uidx=%0d want 02 1 03 0",
                     bus.lower, bus.lower_idx, bus.upper, bus.upper_idx);
        else passed++;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        total++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.lower !== 5'd0 || bus.upper !== 5'd0 || bus.lower_valid !== 1'b0)
            $display("FAIL b2b_accept_edge6 busy=%b done=%b lower=%h upper=%h lv=%b want 1 0 00 00 0",
                     bus.busy, bus.done, bus.lower, bus.upper, bus.lower_valid);
        else passed++;
        wait_done(n);
        total++;
        if (n !== 5) $display("FAIL b2b_second_latency done_edge=%0d want 11 (5 after edge 6)", n + 6);
        else passed++;
        total++;
        if (bus.lower !== 5'd1 || bus.lower_idx !== 2'd0 || bus.lower_valid !== 1'b1)
            $display("FAIL b2b_second_lower lower=%h idx=%0d valid=%b want 01 0 1", bus.lower, bus.lower_idx, bus.lower_valid);
        else passed++;
        total++;
        if (bus.upper !== 5'h1D || bus.upper_idx !== 2'd3 || bus.upper_valid !== 1'b1)
            $display("FAIL b2b_second_upper upper=%h idx=%0d valid=%b want 1d 3 1", bus.upper, bus.upper_idx, bus.upper_valid);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL b2b_idle busy=%b done=%b want 0 0", bus.busy, bus.done);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_mixed();
        test_none_active();
        test_negate_min();
        test_tie();
        test_start_ignored();
        test_reset_mid_scan();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
